// File: rtl/alarm_tone_scheduler_pkg.sv
// Shared types and constants for the alarm/chime/beep tone scheduler.
// Holds the FSM state encoding, source codes, melody ROM entry layout and base addresses.
package alarm_tone_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP,
    ST_CHIME,
    ST_ALARM,
    ST_GAP
  } state_t;

  localparam logic [1:0] SRC_IDLE  = 2'b00;
  localparam logic [1:0] SRC_BEEP  = 2'b01;
  localparam logic [1:0] SRC_CHIME = 2'b10;
  localparam logic [1:0] SRC_ALARM = 2'b11;

  localparam int ROM_AW = 4;
  localparam int ROM_DW = 9;
  localparam int NOTE_W = 3;
  localparam int DUR_W  = 4;

  localparam logic [ROM_AW-1:0] ALARM_BASE = 4'd0;
  localparam logic [ROM_AW-1:0] CHIME_BASE = 4'd12;
  localparam logic [7:0]        BEEP_NOTE  = 8'b1000_0000;

  typedef struct packed {
    logic              last;
    logic              rest;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // GAP is part of the alarm source, so it reports the alarm code.
  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      ST_BEEP:          src_of = SRC_BEEP;
      ST_CHIME:         src_of = SRC_CHIME;
      ST_ALARM, ST_GAP: src_of = SRC_ALARM;
      default:          src_of = SRC_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_tone_scheduler_melody_rom.sv
// Combinational 16-entry melody table: alarm tune from entry 0, hourly chime from entry 12.
// Entry layout is {end, rest, note[2:0], dur[3:0]}; dur of zero plays as one unit.
module melody_rom
  import alarm_tone_scheduler_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] data
);

  always_comb begin
    case (addr)
      4'd0:    data = 9'b0_0_000_0010;
      4'd1:    data = 9'b0_0_010_0001;
      4'd2:    data = 9'b0_1_000_0001;
      4'd3:    data = 9'b1_0_100_0010;
      4'd12:   data = 9'b0_0_101_0001;
      4'd13:   data = 9'b0_0_100_0000;
      4'd14:   data = 9'b0_1_000_0001;
      4'd15:   data = 9'b1_0_000_0010;
      // unused slots terminate immediately as a one-unit rest
      default: data = 9'b1_1_000_0001;
    endcase
  end

endmodule

// File: rtl/alarm_tone_scheduler.sv
// Schedules alarm, hourly chime and key-beep tones onto a one-hot note bus with a codec gate.
// A tick divider that restarts on every note load times notes, beeps and the alarm repeat gap.
module alarm_tone_scheduler
  import alarm_tone_scheduler_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int TICK_HZ    = 100,
  parameter int DUR_TICKS  = 5,
  parameter int BEEP_TICKS = 5,
  parameter int GAP_TICKS  = 50
) (
  input  logic       CLOCK,
  input  logic       DLY_RST,
  input  logic       alarm_req,
  input  logic       chime_req,
  input  logic       beep_req,
  input  logic       stop,
  output logic [7:0] music,
  output logic       tone_en,
  output logic       busy,
  output logic [1:0] src,
  output logic       melody_done
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_t              state, state_nxt;
  logic [ROM_AW-1:0]   addr, addr_nxt;
  logic [ROM_DW-1:0]   rom_data;
  rom_entry_t          entry;
  logic [DIV_W-1:0]    div_cnt;
  logic [15:0]         tick_cnt;
  logic [15:0]         target;
  logic [DUR_W-1:0]    dur_eff;
  logic                tick, last_tick, load;
  logic                pend, pend_nxt;
  logic                rearm;
  logic                done_nxt;
  logic                alarm_go;

  melody_rom u_rom (
    .addr (addr),
    .data (rom_data)
  );

  assign entry    = rom_entry_t'(rom_data);
  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign dur_eff  = (entry.dur == '0) ? DUR_W'(1) : entry.dur;
  assign alarm_go = alarm_req && rearm;

  always_comb begin
    case (state)
      ST_BEEP: target = 16'(BEEP_TICKS);
      ST_GAP:  target = 16'(GAP_TICKS);
      default: target = {12'd0, dur_eff} * 16'(DUR_TICKS);
    endcase
  end

  assign last_tick = tick && (tick_cnt == target - 16'd1);

  always_ff @(posedge CLOCK or negedge DLY_RST) begin
    if (!DLY_RST) begin
      state       <= ST_IDLE;
      addr        <= '0;
      pend        <= 1'b0;
      rearm       <= 1'b1;
      melody_done <= 1'b0;
      div_cnt     <= '0;
      tick_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      pend        <= pend_nxt;
      melody_done <= done_nxt;
      // a dismissed alarm stays quiet until alarm_req has been seen low
      if (!alarm_req)
        rearm <= 1'b1;
      else if (stop)
        rearm <= 1'b0;
      if (load) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick)
          tick_cnt <= tick_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    pend_nxt  = pend;
    load      = 1'b0;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      pend_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alarm_go) begin
            state_nxt = ST_ALARM;
            addr_nxt  = ALARM_BASE;
            load      = 1'b1;
          end else if (chime_req || pend) begin
            state_nxt = ST_CHIME;
            addr_nxt  = CHIME_BASE;
            pend_nxt  = 1'b0;
            load      = 1'b1;
          end else if (beep_req) begin
            state_nxt = ST_BEEP;
            load      = 1'b1;
          end
        end
        ST_BEEP: begin
          if (alarm_go) begin
            state_nxt = ST_ALARM;
            addr_nxt  = ALARM_BASE;
            load      = 1'b1;
          end else begin
            if (chime_req)
              pend_nxt = 1'b1;
            if (last_tick) begin
              if (pend || chime_req) begin
                state_nxt = ST_CHIME;
                addr_nxt  = CHIME_BASE;
                pend_nxt  = 1'b0;
                load      = 1'b1;
              end else begin
                state_nxt = ST_IDLE;
              end
            end
          end
        end
        ST_CHIME: begin
          if (alarm_go) begin
            state_nxt = ST_ALARM;
            addr_nxt  = ALARM_BASE;
            load      = 1'b1;
          end else if (last_tick) begin
            if (entry.last) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              addr_nxt = addr + ROM_AW'(1);
              load     = 1'b1;
            end
          end
        end
        ST_ALARM: begin
          if (!alarm_req) begin
            state_nxt = ST_IDLE;
          end else if (last_tick) begin
            if (entry.last) begin
              state_nxt = ST_GAP;
            end else begin
              addr_nxt = addr + ROM_AW'(1);
            end
            load = 1'b1;
          end
        end
        ST_GAP: begin
          if (!alarm_req) begin
            state_nxt = ST_IDLE;
          end else if (last_tick) begin
            state_nxt = ST_ALARM;
            addr_nxt  = ALARM_BASE;
            load      = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state registers so reset silences them at once.
  always_comb begin
    music   = '0;
    tone_en = 1'b0;
    case (state)
      ST_BEEP: begin
        music   = BEEP_NOTE;
        tone_en = 1'b1;
      end
      ST_CHIME, ST_ALARM: begin
        if (!entry.rest) begin
          music   = 8'b1 << entry.note;
          tone_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign src  = src_of(state);

endmodule

// File: doc/alarm_tone_scheduler.md
ALARM_TONE_SCHEDULER -- requirements
Module: alarm_tone_scheduler

Interface
REQ-001 SHALL have parameters: CLK_FREQ, 50000000, input clock Hz; TICK_HZ, 100, timebase tick rate; DUR_TICKS, 5, ticks per duration unit; BEEP_TICKS, 5, key-beep length in ticks; GAP_TICKS, 50, silence between alarm repeats.
REQ-002 SHALL have ports: CLOCK in 1, system clock; DLY_RST in 1, reset, asynchronous, active-low; alarm_req in 1, level, alarm active; chime_req in 1, one-cycle hourly-chime pulse; beep_req in 1, one-cycle key-beep pulse; stop in 1, one-cycle dismiss pulse.
REQ-003 SHALL have outputs: music out 8, one-hot note select (bit0=DO ... bit7=DO1), all-zero when silent; tone_en out 1, drives the codec ALM gate; busy out 1, any source playing; src out 2, 00 idle / 01 beep / 10 chime / 11 alarm; melody_done out 1, one-cycle pulse.

Function
REQ-004 SHALL generate a one-cycle tick every CLK_FREQ/TICK_HZ cycles; the tick divider SHALL restart at 0 on every note load, so each note lasts exactly dur*DUR_TICKS*(CLK_FREQ/TICK_HZ) cycles.
REQ-005 SHALL read a 16-entry melody ROM; entry = {end, rest, note[2:0], dur[3:0]}; alarm melody starts at 0, chime at 12; dur=0 SHALL be treated as 1.
REQ-006 SHALL run FSM states IDLE, BEEP, CHIME, ALARM, GAP.
REQ-007 IDLE: priority alarm_req > chime_req (or pending chime) > beep_req; selected state and first note SHALL appear on registered outputs the cycle after the request is sampled.
REQ-008 ALARM: play entries from 0; after an entry with end=1 go to GAP; GAP holds silence GAP_TICKS ticks, then returns to ALARM at entry 0 if alarm_req still high, else IDLE.
REQ-009 CHIME: play entries from 12 until end=1, then pulse melody_done and go to IDLE.
REQ-010 BEEP: music=8'b1000_0000, tone_en=1 for BEEP_TICKS ticks, then IDLE (serve pending chime first if set).
REQ-011 Playing note: music=1<<note, tone_en=1; rest entry: music=0, tone_en=0 (codec holds last note, so tone_en SHALL gate silence).
REQ-012 alarm_req rising during CHIME or BEEP SHALL abort that source and enter ALARM at entry 0 the next cycle; no melody_done.
REQ-013 chime_req during BEEP SHALL set a 1-bit pending flag; during CHIME, ALARM or GAP it SHALL be dropped.
REQ-014 beep_req while busy SHALL be dropped.
REQ-015 alarm_req low in ALARM or GAP SHALL return to IDLE next cycle, music=0, tone_en=0.
REQ-016 stop in any state SHALL return to IDLE next cycle, clear pending chime; alarm_req still high SHALL NOT restart the alarm until alarm_req has gone low and high again (rearm flag).
REQ-017 stop and a request in the same cycle: stop wins, request dropped.
REQ-018 busy SHALL equal (state != IDLE); src SHALL follow the state (GAP reports 11).

Reset
REQ-019 DLY_RST low SHALL asynchronously force IDLE, music=0, tone_en=0, busy=0, src=00, melody_done=0, tick divider=0, ROM address=0, pending chime=0, rearm flag=1.
REQ-020 Reset mid-note SHALL silence outputs immediately; no resume after release.

Structure
REQ-021 Shared package SHALL hold the state enum, src codes, ROM entry field widths, ALARM_BASE=0, CHIME_BASE=12, BEEP_NOTE one-hot.
REQ-022 ROM contents SHALL live in sub-module melody_rom (combinational, 4-bit address, 9-bit data).

Verification (CLK_FREQ=1000, TICK_HZ=100: 10 cycles/tick, 50 cycles/unit)
REQ-023 beep_req pulse at cycle 0 -> music=8'h80, tone_en=1, src=01 from cycle 1 for exactly 50 cycles, then all zero.
REQ-024 chime_req in IDLE -> entries 12..end played with exact lengths, melody_done pulse 1 cycle after last note ends, src=00.
REQ-025 alarm_req held high -> melody, 500-cycle silent GAP, repeat from entry 0; drop alarm_req mid-note -> silent next cycle.
REQ-026 alarm_req, chime_req, beep_req same cycle -> src=11; chime during BEEP -> chime plays right after beep ends.
REQ-027 stop while alarm_req stays high -> IDLE, no restart; alarm_req low then high -> alarm restarts at entry 0.
REQ-028 DLY_RST low mid-chime -> outputs zero same cycle, IDLE after release, no melody_done.
